// File: rtl/avalon_mm_arbiter_pkg.sv
// avalon_arb_pkg: shared types and widths for the Avalon-MM two-port arbiter
package avalon_arb_pkg;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam logic BURST_ONE = 1'b1;
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/avalon_mm_arbiter_if.sv
// avalon_mm_arbiter_if: Avalon-MM bus between the arbiter (master) and the bridge (slave)
interface avalon_mm_arbiter_if;
    import avalon_arb_pkg::*;
    logic [ADDR_W-1:0] address;
    logic read;
    logic write;
    logic [DATA_W-1:0] writedata;
    logic [3:0] byteenable;
    logic burstcount;
    logic debugaccess;
    logic waitrequest;
    logic [DATA_W-1:0] readdata;
    logic readdatavalid;
    modport master (
        output address, read, write, writedata, byteenable, burstcount, debugaccess,
        input waitrequest, readdata, readdatavalid
    );
    modport slave (
        input address, read, write, writedata, byteenable, burstcount, debugaccess,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_mm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; a tie goes to the port not granted last
module rr_arb2
    import avalon_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_req,
    input  logic  d_req,
    input  logic  accept,
    output port_t gnt
);
    port_t last;
    always_comb gnt = (i_req && d_req) ? (last == PORT_D ? PORT_I : PORT_D) : (i_req ? PORT_I : PORT_D);
    always_ff @(posedge clk) begin
        if (rst) last <= PORT_D;
        else if (accept) last <= gnt;
    end
endmodule

// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter: shares one Avalon-MM bridge between instruction fetch and load/store, one transaction at a time
module avalon_mm_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter logic [DATA_W-1:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    avalon_mm_arbiter_if.master m
);
    localparam int CW = $clog2(TIMEOUT);
    state_t state;
    port_t gnt, port;
    logic take;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] rsp;
    assign take = state == IDLE && (i_req || d_req);
    assign rsp = m.readdatavalid ? m.readdata : ERR_WORD;
    assign m.burstcount = BURST_ONE;
    assign m.debugaccess = 1'b0;
    rr_arb2 u_arb (
        .clk(clk_clk),
        .rst(reset_reset),
        .i_req(i_req),
        .d_req(d_req),
        .accept(take),
        .gnt(gnt)
    );
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            port <= PORT_I;
            cnt <= '0;
            m.read <= 1'b0;
            m.write <= 1'b0;
            m.address <= '0;
            m.writedata <= '0;
            m.byteenable <= '0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_err <= 1'b0;
            d_err <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_err <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    port <= gnt;
                    m.address <= gnt == PORT_I ? i_addr : d_addr;
                    m.writedata <= d_wdata;
                    m.byteenable <= gnt == PORT_I ? 4'hF : d_be;
                    m.read <= gnt == PORT_I || !d_we;
                    m.write <= gnt == PORT_D && d_we;
                    state <= CMD;
                end
                CMD: if (!m.waitrequest) begin
                    m.read <= 1'b0;
                    m.write <= 1'b0;
                    if (m.write) begin
                        d_ack <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= '0;
                        state <= RESP;
                    end
                end
                RESP: if (m.readdatavalid || cnt == CW'(TIMEOUT - 1)) begin
                    if (port == PORT_I) begin
                        i_ack <= 1'b1;
                        i_err <= !m.readdatavalid;
                        i_rdata <= rsp;
                    end else begin
                        d_ack <= 1'b1;
                        d_err <= !m.readdatavalid;
                        d_rdata <= rsp;
                    end
                    state <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
